decode_stage: RTL
=================

# decode_stage

Instruction-decode stage and ID/EX pipeline register of the pipelined processor, driving the ALU control and operand inputs of the execute stage. It holds the 32-entry register file with a write-back port and decodes a 32-bit MIPS-format instruction into `alu_op`, `alu_opcode`, `alu_shamt`, operands and memory/write-back controls. It registers everything into ID/EX with stall and flush support. Decode is combinational from `if_instr`; all outputs are registered, for 1-cycle latency.

## Interface
- `ad_size`, 32, address/PC width
- `d_size`, 32, data/register width
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `if_valid`  in  1  `if_instr`/`if_pc` hold a real instruction
- `if_instr`  in  32  instruction word from IF/ID
- `if_pc`  in  ad_size  PC of `if_instr`
- `stall`  in  1  hold ID/EX contents
- `flush`  in  1  load bubble into ID/EX
- `wb_en`  in  1  register-file write enable
- `wb_addr`  in  5  write-back register index
- `wb_data`  in  d_size  write-back value
- `ex_valid`  out  1  ID/EX holds a valid instruction
- `alu_op`  out  2  00 load/store, 01 branch, 10 R-type
- `alu_opcode`  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 sll
- `alu_shamt`  out  5  shift amount
- `alu_in1`, `alu_in2`  out  d_size  ALU operands
- `ex_store_data`  out  d_size  rt value for sw
- `ex_wr_reg`  out  5  destination register
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch`  out  1 each  stage controls
- `ex_branch_target`  out  ad_size  beq target
- `ex_illegal`  out  1  unsupported instruction was decoded

## Operation
- Fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0]. `sext` = imm sign-extended to d_size.
- R-type, op 0x00:
  - funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or: `alu_op`=10, in1=R[rs], in2=R[rt], wr_reg=rd, reg_write=1.
  - funct 0x00 sll: `alu_opcode`=0111, in1=R[rt], in2=0, `alu_shamt`=shamt, wr_reg=rd, reg_write=1.
  - `alu_shamt`=0 for all non-sll instructions.
- lw, op 0x23: `alu_op`=00, `alu_opcode`=0010, in1=R[rs], in2=sext, wr_reg=rt, reg_write=1, mem_read=1.
- sw, op 0x2B: as lw but reg_write=0, mem_write=1, `ex_store_data`=R[rt].
- beq, op 0x04: `alu_op`=01, `alu_opcode`=0110, in1=R[rs], in2=R[rt], branch=1, target=if_pc+4+(sext<<2), modulo 2^ad_size.
- Unsupported op or funct: bubble loaded (all controls 0, `ex_valid`=0), `ex_illegal`=1 for that entry.
- `ex_reg_write` is forced 0 when the destination is register 0.
- Register file:
  - 32×d_size.
  - R[0] always reads 0; writes to index 0 are ignored.
  - Write when `wb_en`=1 at the clock edge.
  - Same-cycle bypass: a read index equal to a nonzero `wb_addr` with `wb_en`=1 returns `wb_data`.
- Bubble: `ex_valid`=0, `ex_reg_write`/`ex_mem_read`/`ex_mem_write`/`ex_branch`/`ex_illegal`=0, `alu_op`=00, `alu_opcode`=0010, data outputs 0.

## Timing
- Reset (`rst`=0 at edge): all outputs and all 32 registers cleared to 0. This gives a bubble, with `alu_opcode`=0000 only at reset. Reset overrides the in-flight instruction, stall, flush and wb.
- Normal update, per edge with `rst`=1, in priority order:
  - flush=1: bubble.
  - else stall=1: ID/EX holds.
  - else `if_valid`=0: bubble.
  - else: decode result of `if_instr`.
- Register-file writes proceed regardless of stall/flush.
- A stalled entry does not re-read the register file. The EX/MEM hazard unit owns forwarding for stalled operands.
- Latency: instruction present before edge N appears on outputs after edge N.

## Test plan
- Reset: hold `rst`=0 two cycles with `if_valid`=1, add -> all outputs 0, `ex_valid`=0. Then read R[5] via add → in1=0.
- R-type decode: write R1=7, R2=3, then add r3,r1,r2 (0x00221820) -> `alu_op`=10, `alu_opcode`=0010, in1=7, in2=3, wr_reg=3, reg_write=1. Repeat sub/and/or; sll r4,r2,5 -> in1=3, shamt=5, opcode 0111.
- Memory/branch:
  - lw r5,-4(r1) -> `alu_op`=00, in2=0xFFFFFFFC, mem_read=1, wr_reg=5.
  - sw -> mem_write=1, `ex_store_data`=R[rt].
  - beq at pc 0x100 with imm 0xFFFF -> target 0x100, `alu_op`=01, opcode 0110.
- Bypass/r0:
  - `wb_en`=1, `wb_addr`=1, `wb_data`=0xAA with add reading r1 in the same cycle -> in1=0xAA.
  - wb to r0 -> later reads of r0 give 0.
  - add r0,… -> reg_write=0.
- Stall/flush:
  - stall 3 cycles -> outputs unchanged.
  - flush with stall both 1 -> bubble.
  - Unknown op 0x3F -> bubble, `ex_illegal`=1.

Source files
------------

// File: rtl/decode_stage_if.sv
// Bundle of IF/ID inputs, write-back port and ID/EX outputs of the decode stage.
// The slave modport is the decode stage; the master modport is whoever drives it.
interface decode_stage_if #(
    parameter int ad_size = 32,
    parameter int d_size  = 32
);
    logic                if_valid;
    logic [31:0]         if_instr;
    logic [ad_size-1:0]  if_pc;
    logic                stall;
    logic                flush;
    logic                wb_en;
    logic [4:0]          wb_addr;
    logic [d_size-1:0]   wb_data;

    logic                ex_valid;
    logic [1:0]          alu_op;
    logic [3:0]          alu_opcode;
    logic [4:0]          alu_shamt;
    logic [d_size-1:0]   alu_in1;
    logic [d_size-1:0]   alu_in2;
    logic [d_size-1:0]   ex_store_data;
    logic [4:0]          ex_wr_reg;
    logic                ex_reg_write;
    logic                ex_mem_read;
    logic                ex_mem_write;
    logic                ex_branch;
    logic [ad_size-1:0]  ex_branch_target;
    logic                ex_illegal;

    modport slave (
        input  if_valid, if_instr, if_pc, stall, flush, wb_en, wb_addr, wb_data,
        output ex_valid, alu_op, alu_opcode, alu_shamt, alu_in1, alu_in2,
               ex_store_data, ex_wr_reg, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_branch, ex_branch_target, ex_illegal
    );

    modport master (
        output if_valid, if_instr, if_pc, stall, flush, wb_en, wb_addr, wb_data,
        input  ex_valid, alu_op, alu_opcode, alu_shamt, alu_in1, alu_in2,
               ex_store_data, ex_wr_reg, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_branch, ex_branch_target, ex_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS-subset instruction decode with 32-entry register file (write-back bypass)
// and a stallable/flushable ID/EX pipeline register.
module decode_stage #(
    parameter int ad_size = 32,
    parameter int d_size  = 32
) (
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  bus
);
    typedef struct packed {
        logic                valid;
        logic [1:0]          alu_op;
        logic [3:0]          alu_opcode;
        logic [4:0]          alu_shamt;
        logic [d_size-1:0]   in1;
        logic [d_size-1:0]   in2;
        logic [d_size-1:0]   store_data;
        logic [4:0]          wr_reg;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
        logic [ad_size-1:0]  target;
        logic                illegal;
    } idex_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLL = 6'h00;

    // A normal bubble carries the add opcode; only reset leaves alu_opcode at 0000.
    function automatic idex_t bubble(input logic illegal);
        idex_t b;
        b            = '0;
        b.alu_opcode = 4'b0010;
        b.illegal    = illegal;
        return b;
    endfunction

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign op    = bus.if_instr[31:26];
    assign rs    = bus.if_instr[25:21];
    assign rt    = bus.if_instr[20:16];
    assign rd    = bus.if_instr[15:11];
    assign shamt = bus.if_instr[10:6];
    assign funct = bus.if_instr[5:0];
    assign imm   = bus.if_instr[15:0];

    logic [d_size-1:0]  sext;
    logic [ad_size-1:0] br_offset;

    assign sext      = {{(d_size-16){imm[15]}}, imm};
    assign br_offset = {{(ad_size-18){imm[15]}}, imm, 2'b00};

    // Register file: entry 0 is never written and always reads as zero.
    logic [d_size-1:0] rf_reg [32];

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rf
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rf_reg[gi] <= '0;
                end else if (bus.wb_en && bus.wb_addr != 5'd0 && bus.wb_addr == 5'(gi)) begin
                    rf_reg[gi] <= bus.wb_data;
                end
            end
        end
    endgenerate

    // Two read ports with same-cycle write-back bypass.
    logic [4:0]        rd_idx [2];
    logic [d_size-1:0] rd_val [2];

    assign rd_idx[0] = rs;
    assign rd_idx[1] = rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                if (rd_idx[gi] == 5'd0) begin
                    rd_val[gi] = '0;
                end else if (bus.wb_en && bus.wb_addr == rd_idx[gi]) begin
                    rd_val[gi] = bus.wb_data;
                end else begin
                    rd_val[gi] = rf_reg[rd_idx[gi]];
                end
            end
        end
    endgenerate

    idex_t dec_next;

    always_comb begin
        dec_next = bubble(1'b0);
        unique case (op)
            OP_RTYPE: begin
                dec_next.valid     = 1'b1;
                dec_next.alu_op    = 2'b10;
                dec_next.in1       = rd_val[0];
                dec_next.in2       = rd_val[1];
                dec_next.wr_reg    = rd;
                dec_next.reg_write = 1'b1;
                unique case (funct)
                    FN_ADD: dec_next.alu_opcode = 4'b0010;
                    FN_SUB: dec_next.alu_opcode = 4'b0110;
                    FN_AND: dec_next.alu_opcode = 4'b0000;
                    FN_OR:  dec_next.alu_opcode = 4'b0001;
                    FN_SLL: begin
                        dec_next.alu_opcode = 4'b0111;
                        dec_next.in1        = rd_val[1];
                        dec_next.in2        = '0;
                        dec_next.alu_shamt  = shamt;
                    end
                    default: dec_next = bubble(1'b1);
                endcase
            end
            OP_LW: begin
                dec_next.valid     = 1'b1;
                dec_next.in1       = rd_val[0];
                dec_next.in2       = sext;
                dec_next.wr_reg    = rt;
                dec_next.reg_write = 1'b1;
                dec_next.mem_read  = 1'b1;
            end
            OP_SW: begin
                dec_next.valid      = 1'b1;
                dec_next.in1        = rd_val[0];
                dec_next.in2        = sext;
                dec_next.wr_reg     = rt;
                dec_next.mem_write  = 1'b1;
                dec_next.store_data = rd_val[1];
            end
            OP_BEQ: begin
                dec_next.valid      = 1'b1;
                dec_next.alu_op     = 2'b01;
                dec_next.alu_opcode = 4'b0110;
                dec_next.in1        = rd_val[0];
                dec_next.in2        = rd_val[1];
                dec_next.branch     = 1'b1;
                dec_next.target     = bus.if_pc + ad_size'(4) + br_offset;
            end
            default: dec_next = bubble(1'b1);
        endcase
        if (dec_next.wr_reg == 5'd0) begin
            dec_next.reg_write = 1'b0;
        end
    end

    // ID/EX register; a stalled entry keeps its operands as captured.
    idex_t ex_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_reg <= '0;
        end else if (bus.flush) begin
            ex_reg <= bubble(1'b0);
        end else if (!bus.stall) begin
            ex_reg <= bus.if_valid ? dec_next : bubble(1'b0);
        end
    end

    assign bus.ex_valid         = ex_reg.valid;
    assign bus.alu_op           = ex_reg.alu_op;
    assign bus.alu_opcode       = ex_reg.alu_opcode;
    assign bus.alu_shamt        = ex_reg.alu_shamt;
    assign bus.alu_in1          = ex_reg.in1;
    assign bus.alu_in2          = ex_reg.in2;
    assign bus.ex_store_data    = ex_reg.store_data;
    assign bus.ex_wr_reg        = ex_reg.wr_reg;
    assign bus.ex_reg_write     = ex_reg.reg_write;
    assign bus.ex_mem_read      = ex_reg.mem_read;
    assign bus.ex_mem_write     = ex_reg.mem_write;
    assign bus.ex_branch        = ex_reg.branch;
    assign bus.ex_branch_target = ex_reg.target;
    assign bus.ex_illegal       = ex_reg.illegal;
endmodule
